c_requant: RTL and testbench

Downstream consumer of the systolic-array result stream (`m_axis_c`). Takes the row-major M×L stream of OW-bit signed accumulator results and requantizes each element to DW-bit signed using a rounding arithmetic right shift, optional ReLU and saturation. Emits the result as an AXI-Stream with a counter-generated tlast. Runs one element per cycle with a 2-stage valid/ready pipeline and a sticky framing-error flag.

---
 rtl/c_requant_pkg.sv | 44 ++++
 rtl/c_requant_axis_pipe_stage.sv | 53 +++++
 rtl/c_requant.sv | 172 +++++++++++++++++
 tb/tb_c_requant.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_requant_pkg.sv
// Shared helpers for the requantizer: counter sizing, rounding constant and
// saturation to the output width.
package c_requant_pkg;

  localparam int M_DEFAULT = 25;
  localparam int L_DEFAULT = 17;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

  localparam int ROW_CNT_W = cnt_width(M_DEFAULT);
  localparam int COL_CNT_W = cnt_width(L_DEFAULT);

  // Round-half-up bias added before an arithmetic right shift by sh.
  function automatic int round_const(input int sh);
    if (sh == 32'sd0) begin
      return 32'sd0;
    end else begin
      return 32'sd1 <<< (sh - 32'sd1);
    end
  endfunction

  // Clamp a signed value into the two's complement range of a dw-bit word.
  function automatic int sat_to_dw(input int v, input int dw);
    int hi;
    int lo;
    hi = (32'sd1 <<< (dw - 32'sd1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 32'sd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/c_requant_axis_pipe_stage.sv
// One valid/ready register slice. Loads whenever it is empty or its current
// content is taken downstream in the same cycle.
module axis_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next-state: refill or empty the slot only when the downstream side lets go.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/c_requant.sv
// Requantizer for the systolic-array result stream: rounding shift, optional
// ReLU and saturation in a two-slice pipeline; output tlast is generated by
// the frame counters, upstream tlast is only checked.
module c_requant
  import c_requant_pkg::*;
#(
  parameter int M  = 25,
  parameter int L  = 17,
  parameter int OW = 16,
  parameter int DW = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] cfg_shift,
  input  logic          cfg_relu,
  input  logic [OW-1:0] s_axis_c_tdata,
  input  logic          s_axis_c_tvalid,
  output logic          s_axis_c_tready,
  input  logic          s_axis_c_tlast,
  output logic [DW-1:0] m_axis_q_tdata,
  output logic          m_axis_q_tvalid,
  input  logic          m_axis_q_tready,
  output logic          m_axis_q_tlast,
  output logic          err_tlast,
  output logic          frame_done
);

  localparam int RW  = cnt_width(M);
  localparam int CW  = cnt_width(L);
  localparam int TW  = OW + 1;
  localparam int S1W = TW + 2;
  localparam int S2W = DW + 1;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] shift_q, shift_d;
  logic          relu_q, relu_d;
  logic          err_q, err_d;
  logic          frame_done_q, frame_done_d;

  logic          s_fire_s, first_s, last_s, relu_eff_s;
  logic [SW-1:0] sh_eff_s;
  logic signed [TW-1:0] c_ext_s, rnd_s, sum_s, t_s;
  logic [S1W-1:0] s1_in_s, s1_out_s;
  logic           s1_valid_s, s2_ready_s;
  logic signed [TW-1:0] s1_t_s, relu_t_s;
  logic           s1_relu_s, s1_last_s;
  logic [DW-1:0]  q_s;
  logic [S2W-1:0] s2_in_s, s2_out_s;

  assign s_fire_s = s_axis_c_tvalid && s_axis_c_tready;
  assign first_s  = (row_q == {RW{1'b0}}) && (col_q == {CW{1'b0}});
  assign last_s   = (row_q == RW'(M - 1)) && (col_q == CW'(L - 1));

  // The first beat of a frame uses the live config; later beats the latched copy.
  assign sh_eff_s   = first_s ? cfg_shift : shift_q;
  assign relu_eff_s = first_s ? cfg_relu  : relu_q;

  // Stage 1 datapath: one extra bit so the rounding add cannot wrap.
  assign c_ext_s = {s_axis_c_tdata[OW-1], s_axis_c_tdata};
  assign rnd_s   = TW'(round_const(int'(sh_eff_s)));
  assign sum_s   = c_ext_s + rnd_s;
  assign t_s     = sum_s >>> sh_eff_s;
  assign s1_in_s = {relu_eff_s, last_s, t_s};

  axis_pipe_stage #(.W(S1W)) u_stage1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s_axis_c_tvalid),
    .in_data_i   (s1_in_s),
    .in_ready_o  (s_axis_c_tready),
    .out_valid_o (s1_valid_s),
    .out_data_o  (s1_out_s),
    .out_ready_i (s2_ready_s)
  );

  assign s1_relu_s = s1_out_s[S1W-1];
  assign s1_last_s = s1_out_s[S1W-2];
  assign s1_t_s    = s1_out_s[TW-1:0];

  // Stage 2 datapath: ReLU clamp of negative values ahead of saturation.
  always_comb begin
    relu_t_s = s1_t_s;
    if (s1_relu_s && s1_t_s[TW-1]) begin
      relu_t_s = {TW{1'b0}};
    end else begin
      relu_t_s = s1_t_s;
    end
  end

  assign q_s     = DW'(sat_to_dw(int'(relu_t_s), DW));
  assign s2_in_s = {s1_last_s, q_s};

  axis_pipe_stage #(.W(S2W)) u_stage2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_valid_s),
    .in_data_i   (s2_in_s),
    .in_ready_o  (s2_ready_s),
    .out_valid_o (m_axis_q_tvalid),
    .out_data_o  (s2_out_s),
    .out_ready_i (m_axis_q_tready)
  );

  assign m_axis_q_tlast = s2_out_s[S2W-1];
  assign m_axis_q_tdata = s2_out_s[DW-1:0];
  assign err_tlast      = err_q;
  assign frame_done     = frame_done_q;

  // Frame counters, config latch and sticky framing check on accepted beats.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    err_d   = err_q;
    if (s_fire_s) begin
      if (col_q == CW'(L - 1)) begin
        col_d = {CW{1'b0}};
        if (row_q == RW'(M - 1)) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
        row_d = row_q;
      end
      if (first_s) begin
        shift_d = cfg_shift;
        relu_d  = cfg_relu;
      end else begin
        shift_d = shift_q;
        relu_d  = relu_q;
      end
      if (s_axis_c_tlast != last_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Pulse once after the handshake of the counter-marked last output beat.
  always_comb begin
    frame_done_d = m_axis_q_tvalid && m_axis_q_tready && m_axis_q_tlast;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= {RW{1'b0}};
      col_q        <= {CW{1'b0}};
      shift_q      <= {SW{1'b0}};
      relu_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_c_requant.sv
// Self-checking bench for c_requant: table vectors, full frames with and
// without backpressure, framing error and mid-frame reset.
module tb_c_requant;
  localparam int M = 25, L = 17, OW = 16, DW = 8, SW = 4;
  localparam int N = M * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] cfg_shift = '0;
  logic          cfg_relu = 1'b0;
  logic [OW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          err_tlast;
  logic          frame_done;

  always #5 clk = ~clk;

  c_requant #(.M(M), .L(L), .OW(OW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .s_axis_c_tdata(s_tdata), .s_axis_c_tvalid(s_tvalid), .s_axis_c_tready(s_tready),
    .s_axis_c_tlast(s_tlast), .m_axis_q_tdata(m_tdata), .m_axis_q_tvalid(m_tvalid),
    .m_axis_q_tready(m_tready), .m_axis_q_tlast(m_tlast), .err_tlast(err_tlast),
    .frame_done(frame_done));

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct { logic [DW-1:0] d; logic last; int cyc; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] ref_log[$];

  typedef struct { logic [OW-1:0] c; logic [SW-1:0] sh; logic relu; logic [DW-1:0] q; } vec_t;
  vec_t tbl[10];

  logic [OW-1:0] fr[N];
  int  cyc = 0, idx_m = 0, fd_cnt = 0, tl_cnt = 0, full_seen = 0;
  int  bp_mode = 0;    // 0: ready high, 1: random, 2: ready low
  bit  gap_mode = 1'b0;
  bit  chk_lat = 1'b0;
  logic [SW-1:0] lat_sh = '0;
  logic lat_relu = 1'b0;
  bit  err_m = 1'b0;
  bit  prev_stall = 1'b0, prev_last_fire = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic prev_l = 1'b0;

  // Reference: exact round-half-up division by 2^sh, then ReLU, then clamp.
  function automatic logic [DW-1:0] ref_q(input int c, input int sh, input bit relu);
    int d, num, q, hi, lo;
    logic [31:0] qv;
    d   = 1 << sh;
    num = c + ((sh == 0) ? 0 : d / 2);
    if (num >= 0) q = num / d;
    else          q = -((-num + d - 1) / d);
    if (relu && q < 0) q = 0;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    qv = q;
    return qv[DW-1:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, scoreboards both stream sides.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        idx_m = 0; err_m = 1'b0; prev_stall = 1'b0; prev_last_fire = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_tvalid, 1);
          check("hold_data", m_tdata, prev_d);
          check("hold_last", m_tlast, prev_l);
        end
        check("frame_done", frame_done, prev_last_fire);
        if (frame_done) fd_cnt++;
        check("s_ready", s_tready, (sb.size() < 2) || m_tready);
        if (sb.size() == 2 && !m_tready) full_seen++;
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_data", m_tdata, e.d);
            check("out_last", m_tlast, e.last);
            if (chk_lat) check("latency", cyc - e.cyc, 2);
            out_log.push_back(m_tdata);
            if (m_tlast) tl_cnt++;
          end
        end
        prev_stall     = m_tvalid && !m_tready;
        prev_d         = m_tdata;
        prev_l         = m_tlast;
        prev_last_fire = m_tvalid && m_tready && m_tlast;
        check("err_tlast", err_tlast, err_m);
        if (s_tvalid && s_tready) begin
          if (idx_m == 0) begin lat_sh = cfg_shift; lat_relu = cfg_relu; end
          e.d = ref_q($signed(s_tdata), int'(lat_sh), lat_relu);
          e.last = (idx_m == N - 1);
          e.cyc = cyc;
          sb.push_back(e);
          if (s_tlast != (idx_m == N - 1)) err_m = 1'b1;
          idx_m = (idx_m == N - 1) ? 0 : idx_m + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(1, 0) == 1);
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic send_beat(input logic [OW-1:0] c, input logic tl);
    int budget;
    bit done;
    budget = 0; done = 1'b0;
    s_tdata = c; s_tlast = tl;
    while (!done) begin
      s_tvalid = gap_mode ? ($urandom_range(3, 0) != 0) : 1'b1;
      @(negedge clk);
      if (s_tvalid && s_tready) done = 1'b1;
      tick();
      budget++;
      if (!done && budget > 1000) begin
        check("input_timeout", 0, 1);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nb, input logic [SW-1:0] sh, input logic relu, input bit bad);
    for (int i = 0; i < nb; i++) begin
      cfg_shift = (i == 0) ? sh : SW'($urandom);
      cfg_relu  = (i == 0) ? relu : 1'($urandom);
      send_beat(fr[i], bad ? (i == 99) : (i == N - 1));
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 3000) begin tick(); b++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    tick(); tick(); tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) fr[i] = OW'($urandom);
    fr[1] = 16'h7FFF; fr[2] = 16'h8000; fr[3] = 16'h0000; fr[4] = 16'hFFFF;
  endtask

  task automatic new_frame_stats();
    out_log.delete(); tl_cnt = 0; fd_cnt = 0;
  endtask

  initial begin
    tbl[0] = '{16'h0123, 4'd4,  1'b0, 8'h12};
    tbl[1] = '{16'h0005, 4'd0,  1'b0, 8'h05};
    tbl[2] = '{16'hFED4, 4'd2,  1'b0, 8'hB5};
    tbl[3] = '{16'h7FFF, 4'd0,  1'b0, 8'h7F};
    tbl[4] = '{16'h8000, 4'd0,  1'b0, 8'h80};
    tbl[5] = '{16'h7FFF, 4'd1,  1'b0, 8'h7F};
    tbl[6] = '{16'h8000, 4'd0,  1'b1, 8'h00};
    tbl[7] = '{16'h8000, 4'd15, 1'b0, 8'hFF};
    tbl[8] = '{16'hFFFC, 4'd3,  1'b0, 8'h00};
    tbl[9] = '{16'hFFFB, 4'd3,  1'b0, 8'hFF};

    // Reset state
    #12;
    check("rst_valid", m_tvalid, 0);
    check("rst_data", m_tdata, 0);
    check("rst_last", m_tlast, 0);
    check("rst_err", err_tlast, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ready", s_tready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table vectors: each is the first beat of a frame with its own config
    bp_mode = 1; gap_mode = 1'b1;
    for (int v = 0; v < 10; v++) begin
      fill_random();
      fr[0] = tbl[v].c;
      new_frame_stats();
      send_frame(N, tbl[v].sh, tbl[v].relu, 1'b0);
      drain();
      check("tbl_count", out_log.size(), N);
      if (out_log.size() > 0) check($sformatf("tbl_%0d", v), out_log[0], tbl[v].q);
      check("tbl_tlast_cnt", tl_cnt, 1);
      check("tbl_fd_cnt", fd_cnt, 1);
    end

    // Full frame without stalls, 2-cycle latency
    fill_random();
    bp_mode = 0; gap_mode = 1'b0; chk_lat = 1'b1;
    tick();
    new_frame_stats();
    send_frame(N, 4'd3, 1'b0, 1'b0);
    drain();
    chk_lat = 1'b0;
    check("full_count", out_log.size(), N);
    check("full_tlast_cnt", tl_cnt, 1);
    check("full_fd_cnt", fd_cnt, 1);
    check("full_err", err_tlast, 0);
    ref_log = out_log;

    // Same frame under random backpressure
    bp_mode = 1; gap_mode = 1'b1; full_seen = 0;
    new_frame_stats();
    send_frame(N, 4'd3, 1'b0, 1'b0);
    drain();
    check("bp_count", out_log.size(), N);
    for (int i = 0; i < N && i < out_log.size(); i++)
      if (out_log[i] !== ref_log[i]) check($sformatf("bp_seq_%0d", i), out_log[i], ref_log[i]);
    check("bp_full_seen", full_seen > 0, 1);
    check("bp_tlast_cnt", tl_cnt, 1);

    // Framing error: tlast on beat 100, missing on beat 425
    fill_random();
    new_frame_stats();
    send_frame(N, 4'd6, 1'b1, 1'b1);
    drain();
    check("ferr_flag", err_tlast, 1);
    check("ferr_tlast_cnt", tl_cnt, 1);
    fill_random();
    new_frame_stats();
    send_frame(N, 4'd2, 1'b0, 1'b0);
    drain();
    check("ferr_sticky", err_tlast, 1);
    check("ferr2_tlast_cnt", tl_cnt, 1);
    check("ferr2_fd_cnt", fd_cnt, 1);

    // Reset mid-frame with the output stalled
    fill_random();
    send_frame(200, 4'd1, 1'b0, 1'b0);
    bp_mode = 2;
    tick(); tick(); tick();
    check("pre_rst_valid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_tvalid, 0);
    check("mid_rst_data", m_tdata, 0);
    check("mid_rst_last", m_tlast, 0);
    check("mid_rst_err", err_tlast, 0);
    check("mid_rst_fd", frame_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    bp_mode = 1;
    tick();
    fill_random();
    new_frame_stats();
    send_frame(N, 4'd5, 1'b1, 1'b0);
    drain();
    check("post_rst_count", out_log.size(), N);
    check("post_rst_tlast_cnt", tl_cnt, 1);
    check("post_rst_fd_cnt", fd_cnt, 1);
    check("post_rst_err", err_tlast, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
